// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: drives datapath selects/enables and waits on mem_ready.
// Optional JUMP support is compiled in with `define MULTICYCLE_JUMP_EN.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state_out,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10
`ifdef MULTICYCLE_JUMP_EN
    , JUMP  = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  // Moore control word for each state; FETCH enables are gated by mem_ready later.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:  c.alu_src_b = 2'b11;
      MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      EXECUTE: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BRANCH:  begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB:  c.reg_write = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      JUMP:    begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  logic   is_sw_q;
  logic   illegal_dec;
  logic   retire;
  logic   fetch_en;

  always_comb begin
    state_nxt   = state_q;
    illegal_dec = 1'b0;
    case (state_q)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_nxt = JUMP;
`endif
          default: begin
            state_nxt   = FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      MEMADR:  state_nxt = is_sw_q ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_nxt = MEMWB;
      MEMWR:   if (mem_ready) state_nxt = FETCH;
      EXECUTE: state_nxt = ALUWB;
      ADDIEX:  state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  // Every return to FETCH except the illegal-decode one retires an instruction.
  assign retire = (state_nxt == FETCH) && (state_q != FETCH) && (state_q != DECODE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      ctrl_q      <= ctrl_for(FETCH);
      is_sw_q     <= 1'b0;
      illegal_op  <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state_q     <= state_nxt;
      ctrl_q      <= ctrl_for(state_nxt);
      illegal_op  <= illegal_dec;
      cycle_count <= cycle_count + CNT_W'(1);
      if (state_q == DECODE) is_sw_q <= (opcode == OP_SW);
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Reset also masks the fetch enables so an asserted reset never loads PC or IR.
  assign fetch_en  = ctrl_q.fetch & mem_ready & reset;
  assign PCWrite   = ctrl_q.pc_write | fetch_en;
  assign IRWrite   = fetch_en;
  assign Branch    = ctrl_q.branch;
  assign IorD      = ctrl_q.iord;
  assign MemWrite  = ctrl_q.mem_write;
  assign RegDst    = ctrl_q.reg_dst;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign RegWrite  = ctrl_q.reg_write;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign PCSrc     = ctrl_q.pc_src;
  assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle vector table plus reset and wrap sequences.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic [3:0]  state_out;
  logic        illegal_op;
  logic [31:0] cycle_count, instr_count;

  logic        PCWrite_4, Branch_4, IorD_4, MemWrite_4, IRWrite_4, RegDst_4, MemtoReg_4;
  logic        RegWrite_4, ALUSrcA_4;
  logic [1:0]  ALUSrcB_4, ALUOp_4, PCSrc_4;
  logic [3:0]  state_out_4;
  logic        illegal_op_4;
  logic [3:0]  cycle_count_4, instr_count_4;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .state_out(state_out), .illegal_op(illegal_op),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite_4), .Branch(Branch_4), .IorD(IorD_4), .MemWrite(MemWrite_4),
    .IRWrite(IRWrite_4), .RegDst(RegDst_4), .MemtoReg(MemtoReg_4), .RegWrite(RegWrite_4),
    .ALUSrcA(ALUSrcA_4), .ALUSrcB(ALUSrcB_4), .ALUOp(ALUOp_4), .PCSrc(PCSrc_4),
    .state_out(state_out_4), .illegal_op(illegal_op_4),
    .cycle_count(cycle_count_4), .instr_count(instr_count_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;

  // {PCWrite,Branch,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  localparam logic [14:0] C_FON  = 15'b1_0_0_0_1_0_0_0_0_01_00_00;
  localparam logic [14:0] C_FOFF = 15'b0_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] C_DEC  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] C_MADR = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] C_MRD  = 15'b0_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_MWB  = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [14:0] C_MWR  = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_EXE  = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] C_AWB  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] C_BR   = 15'b0_1_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] C_AIWB = 15'b0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [14:0] C_JMP  = 15'b1_0_0_0_0_0_0_0_0_00_00_10;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        ill;
    int unsigned icnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned exp_cyc;

  task automatic add(input logic rst_n, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [14:0] ctl, input logic ill,
                     input int unsigned icnt);
    vec_t v;
    v.rst_n = rst_n; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.ill = ill; v.icnt = icnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] obs();
    return {PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, ALUOp, PCSrc};
  endfunction

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = R;
    #2 reset = 1'b0;

    // R-type, lw with MEMRD stalls, sw with FETCH/MEMWR stalls, beq, illegal, addi, j
    add(0, R,    1, 0,  C_FOFF, 0, 0);
    add(1, R,    1, 0,  C_FON,  0, 0);
    add(1, R,    1, 1,  C_DEC,  0, 0);
    add(1, R,    1, 6,  C_EXE,  0, 0);
    add(1, R,    1, 7,  C_AWB,  0, 0);
    add(1, LW,   1, 0,  C_FON,  0, 1);
    add(1, LW,   1, 1,  C_DEC,  0, 1);
    add(1, LW,   1, 2,  C_MADR, 0, 1);
    add(1, LW,   0, 3,  C_MRD,  0, 1);
    add(1, LW,   0, 3,  C_MRD,  0, 1);
    add(1, LW,   1, 3,  C_MRD,  0, 1);
    add(1, LW,   1, 4,  C_MWB,  0, 1);
    add(1, SW,   0, 0,  C_FOFF, 0, 2);
    add(1, SW,   1, 0,  C_FON,  0, 2);
    add(1, SW,   1, 1,  C_DEC,  0, 2);
    add(1, SW,   1, 2,  C_MADR, 0, 2);
    add(1, SW,   0, 5,  C_MWR,  0, 2);
    add(1, SW,   1, 5,  C_MWR,  0, 2);
    add(1, BEQ,  1, 0,  C_FON,  0, 3);
    add(1, BEQ,  1, 1,  C_DEC,  0, 3);
    add(1, BEQ,  1, 8,  C_BR,   0, 3);
    add(1, ILL,  1, 0,  C_FON,  0, 4);
    add(1, ILL,  1, 1,  C_DEC,  0, 4);
    add(1, ADDI, 1, 0,  C_FON,  1, 4);
    add(1, ADDI, 1, 1,  C_DEC,  0, 4);
    add(1, ADDI, 1, 9,  C_MADR, 0, 4);
    add(1, ADDI, 1, 10, C_AIWB, 0, 4);
    add(1, J,    1, 0,  C_FON,  0, 5);
    add(1, J,    1, 1,  C_DEC,  0, 5);
`ifdef MULTICYCLE_JUMP_EN
    add(1, J,    1, 11, C_JMP,  0, 5);
    add(1, R,    0, 0,  C_FOFF, 0, 6);
`else
    add(1, R,    0, 0,  C_FOFF, 1, 5);
`endif

    exp_cyc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n; opcode = vecs[i].op; mem_ready = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("v%0d state", i), state_out, vecs[i].st);
      chk($sformatf("v%0d ctrl", i), obs(), vecs[i].ctl);
      chk($sformatf("v%0d illegal", i), illegal_op, vecs[i].ill);
      chk($sformatf("v%0d instr_count", i), instr_count, vecs[i].icnt);
      chk($sformatf("v%0d cycle_count", i), cycle_count, exp_cyc);
      @(posedge clk); #1;
      if (vecs[i].rst_n) exp_cyc++;
    end

    // Asynchronous reset while in ADDIEX abandons the addi without a register write
    reset = 1'b0; opcode = ADDI; mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("addiex reached", state_out, 4'd9);
    #2 reset = 1'b0;
    #1;
    chk("async state", state_out, 4'd0);
    chk("async cycle_count", cycle_count, 0);
    chk("async instr_count", instr_count, 0);
    chk("async regwrite", RegWrite, 1'b0);
    chk("async ctrl", obs(), C_FOFF);
    @(posedge clk); #1;
    mem_ready = 1'b0; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset %0d state/regwrite", k), {state_out, RegWrite}, {4'd0, 1'b0});
      @(posedge clk); #1;
    end

    // 16 back-to-back beqs (3 cycles each) wrap the 4-bit retire counter
    reset = 1'b0; opcode = BEQ; mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    chk("wrap state", state_out, 4'd0);
    chk("wrap instr_count 32b", instr_count, 16);
    chk("wrap cycle_count 32b", cycle_count, 48);
    chk("wrap instr_count 4b", instr_count_4, 4'd0);
    chk("wrap cycle_count 4b", cycle_count_4, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post-wrap instr_count 4b", instr_count_4, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
